// File: rtl/timer_bank.sv
// Multi-channel memory-mapped timer: shared prescaler, per-channel count/compare, match/overflow flags, irq_n.
// Latency: writes land on the sampling edge; dout is combinational; flags show one cycle after the tick, irq_n one cycle later.
// Backpressure: none; CPU rd/wr are level strobes with no stall, held writes are idempotent.
module timer_bank #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16,
  parameter int TICK_DIV = 24000,
  parameter int ADDR_W   = $clog2(CHANNELS) + 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rd,
  input  logic              wr,
  input  logic [7:0]        din,
  output logic [7:0]        dout,
  output logic              irq_n
);

  localparam int NB = (WIDTH + 7) / 8;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [3:0]  reg_sel;
  logic [31:0] ch_sel;
  logic [PW-1:0] presc;
  logic        tick;

  logic [7:0]          ch_rdat [CHANNELS];
  logic [CHANNELS-1:0] irq_src;

  assign reg_sel = addr[3:0];

  generate
    if (ADDR_W > 4) begin : g_chsel
      assign ch_sel = 32'(addr[ADDR_W-1:4]);
    end else begin : g_chsel0
      assign ch_sel = 32'd0;
    end
  endgenerate

  assign tick = (presc == PRE_LAST);

  // Free-running prescaler, wraps after TICK_DIV cycles; only reset stops it.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [WIDTH-1:0] cnt, snap, cmp;
    logic [WIDTH-1:0] cnt_wdat, cmp_wdat, cnt_nxt;
    logic [4:0]       ctl, ctl_eff;
    logic [1:0]       sts;
    logic             rd0_q;
    logic             sel, wr_ch, rd0;
    logic             cnt_wr, cmp_wr, ctl_wr, sts_wr;
    logic             set_m, set_o, os_clr;
    logic [31:0]      snap32, cmp32;

    assign sel    = cs && (ch_sel == gi);
    assign wr_ch  = sel && wr;
    assign rd0    = sel && rd && (reg_sel == 4'd0);
    assign cnt_wr = wr_ch && (32'(reg_sel) < NB);
    assign cmp_wr = wr_ch && (reg_sel >= 4'd4) && (32'(reg_sel) < 4 + NB);
    assign ctl_wr = wr_ch && (reg_sel == 4'd8);
    assign sts_wr = wr_ch && (reg_sel == 4'd9);

    // A control write in the same cycle as a tick decides whether that tick counts.
    assign ctl_eff = ctl_wr ? din[4:0] : ctl;

    // Byte-merge of CPU write data into count and compare.
    always_comb begin
      cnt_wdat = cnt;
      cmp_wdat = cmp;
      for (int i = 0; i < WIDTH; i++) begin
        if (32'(reg_sel) == i / 8)     cnt_wdat[i] = din[i % 8];
        if (32'(reg_sel) == 4 + i / 8) cmp_wdat[i] = din[i % 8];
      end
    end

    // Tick behaviour: a count write suppresses the tick; match has priority over wrap.
    always_comb begin
      cnt_nxt = cnt;
      set_m   = 1'b0;
      set_o   = 1'b0;
      os_clr  = 1'b0;
      if (cnt_wr) begin
        cnt_nxt = cnt_wdat;
      end else if (tick && ctl_eff[0]) begin
        if (cnt == cmp) begin
          set_m   = 1'b1;
          cnt_nxt = ctl_eff[1] ? '0 : cnt + 1'b1;
          os_clr  = ctl_eff[2];
        end else if (&cnt) begin
          set_o   = 1'b1;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
    end

    // Channel state; a control write overrides the one-shot EN clear, a flag set overrides W1C.
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt   <= '0;
        snap  <= '0;
        cmp   <= '1;
        ctl   <= '0;
        sts   <= '0;
        rd0_q <= 1'b0;
      end else begin
        cnt   <= cnt_nxt;
        rd0_q <= rd0;
        if (rd0 && !rd0_q) snap <= cnt;
        if (cmp_wr) cmp <= cmp_wdat;
        if (ctl_wr) ctl <= din[4:0];
        else if (os_clr) ctl[0] <= 1'b0;
        sts <= (sts & ~(sts_wr ? din[1:0] : 2'b00)) | {set_o, set_m};
      end
    end

    assign snap32 = 32'(snap);
    assign cmp32  = 32'(cmp);

    // Register readback; bytes beyond WIDTH come out as zero via zero extension.
    always_comb begin
      ch_rdat[gi] = 8'h00;
      case (reg_sel)
        4'd0, 4'd1, 4'd2, 4'd3: ch_rdat[gi] = snap32[{reg_sel[1:0], 3'b000} +: 8];
        4'd4, 4'd5, 4'd6, 4'd7: ch_rdat[gi] = cmp32[{reg_sel[1:0], 3'b000} +: 8];
        4'd8:                   ch_rdat[gi] = {3'b000, ctl};
        4'd9:                   ch_rdat[gi] = {6'b000000, sts};
        default:                ch_rdat[gi] = 8'h00;
      endcase
    end

    assign irq_src[gi] = (sts[0] & ctl[3]) | (sts[1] & ctl[4]);
  end

  // Read mux: selected channel's byte, zero when not selected.
  always_comb begin
    dout = 8'h00;
    if (cs) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (ch_sel == c) dout = ch_rdat[c];
      end
    end
  end

  // Registered interrupt, active low.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_n <= 1'b1;
    end else begin
      irq_n <= ~|irq_src;
    end
  end

endmodule

// File: tb/tb_timer_bank.sv
module tb_timer_bank;
  localparam int CH = 4;
  localparam int W  = 16;
  localparam int TD = 4;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          reset, cs, rd, wr;
  logic [AW-1:0] addr;
  logic [7:0]    din;
  wire  [7:0]    dout;
  wire           irq_n;

  int errors = 0;
  int checks = 0;

  // Reference state: plain integers, updated from the rules once per clock.
  int unsigned m_cnt [CH];
  int unsigned m_cmp [CH];
  int unsigned m_snap[CH];
  int unsigned m_ctl [CH];
  int unsigned m_sts [CH];
  bit          m_rdq [CH];
  bit          m_irq_n;
  int unsigned m_cyc;

  timer_bank #(.CHANNELS(CH), .WIDTH(W), .TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .cs(cs), .addr(addr), .rd(rd), .wr(wr),
    .din(din), .dout(dout), .irq_n(irq_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] m_read();
    int c, r;
    if (!cs) return 8'h00;
    c = int'(addr) >> 4;
    r = int'(addr) & 15;
    case (r)
      0: return 8'(m_snap[c] & 255);
      1: return 8'((m_snap[c] >> 8) & 255);
      4: return 8'(m_cmp[c] & 255);
      5: return 8'((m_cmp[c] >> 8) & 255);
      8: return 8'(m_ctl[c]);
      9: return 8'(m_sts[c]);
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_step();
    bit tick, w, rr, hit, rd0, cw, ctw, irq;
    int c, r;
    int unsigned ctl_e, ncnt, set, d;
    if (reset) begin
      for (int k = 0; k < CH; k++) begin
        m_cnt[k] = 0; m_snap[k] = 0; m_cmp[k] = 'hFFFF;
        m_ctl[k] = 0; m_sts[k] = 0; m_rdq[k] = 0;
      end
      m_irq_n = 1;
      m_cyc   = 0;
      return;
    end
    tick = (m_cyc % TD) == TD - 1;
    m_cyc++;
    c  = int'(addr) >> 4;
    r  = int'(addr) & 15;
    d  = int'(din);
    w  = cs && wr;
    rr = cs && rd;
    irq = 0;
    for (int k = 0; k < CH; k++)
      if (((m_sts[k] & 1) && (m_ctl[k] & 8)) || ((m_sts[k] & 2) && (m_ctl[k] & 16))) irq = 1;
    m_irq_n = !irq;
    for (int k = 0; k < CH; k++) begin
      hit = (k == c);
      rd0 = rr && hit && r == 0;
      if (rd0 && !m_rdq[k]) m_snap[k] = m_cnt[k];
      m_rdq[k] = rd0;
      cw  = w && hit && r < 2;
      ctw = w && hit && r == 8;
      ctl_e = ctw ? (d & 31) : m_ctl[k];
      set  = 0;
      ncnt = m_cnt[k];
      if (cw) begin
        ncnt = (r == 0) ? ((m_cnt[k] & 'hFF00) | d) : ((m_cnt[k] & 'hFF) | (d << 8));
      end else if (tick && (ctl_e & 1)) begin
        if (m_cnt[k] == m_cmp[k]) begin
          set = 1;
          ncnt = (ctl_e & 2) ? 0 : ((m_cnt[k] + 1) & 'hFFFF);
          if ((ctl_e & 4) && !ctw) m_ctl[k] = m_ctl[k] & ~32'd1;
        end else if (m_cnt[k] == 'hFFFF) begin
          set = 2;
          ncnt = 0;
        end else begin
          ncnt = m_cnt[k] + 1;
        end
      end
      m_cnt[k] = ncnt;
      if (ctw) m_ctl[k] = d & 31;
      if (w && hit && r == 4) m_cmp[k] = (m_cmp[k] & 'hFF00) | d;
      if (w && hit && r == 5) m_cmp[k] = (m_cmp[k] & 'hFF) | (d << 8);
      if (w && hit && r == 9) m_sts[k] = m_sts[k] & ~(d & 3);
      m_sts[k] = m_sts[k] | set;
    end
  endtask

  // One clock: advance the model, let the DUT take the edge, compare outputs.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("irq_n", irq_n, m_irq_n);
    chk("dout", dout, m_read());
  endtask

  task automatic wr_reg(input int c, input int r, input int d);
    cs = 1; wr = 1; rd = 0; addr = AW'(c * 16 + r); din = 8'(d);
    cyc();
    cs = 0; wr = 0;
  endtask

  task automatic rd_reg(input int c, input int r, output logic [7:0] v);
    cs = 1; rd = 1; wr = 0; addr = AW'(c * 16 + r);
    cyc();
    v = dout;
    cs = 0; rd = 0;
  endtask

  task automatic align(input int ph);
    int n = 0;
    while ((m_cyc % TD) != ph && n < 2 * TD) begin cyc(); n++; end
  endtask

  task automatic wait_flag(input int c, input int mask, input string tag);
    int n = 0;
    while ((m_sts[c] & mask) == 0 && n < 200) begin cyc(); n++; end
    if (n >= 200) chk(tag, 0, 1);
  endtask

  logic [7:0] v;

  initial begin
    reset = 1; cs = 0; rd = 0; wr = 0; addr = '0; din = '0;
    cyc(); cyc();
    // reset values, observed while still in the reset cycle
    cs = 1; addr = AW'(2 * 16 + 5); #1 chk("rst_cmp", dout, 8'hFF);
    addr = AW'(2 * 16 + 8); #1 chk("rst_ctl", dout, 8'h00);
    addr = AW'(0); #1 chk("rst_cnt", dout, 8'h00);
    chk("rst_irq", irq_n, 1'b1);
    cs = 0;
    reset = 0;

    // free run: 10 ticks in 40 cycles
    wr_reg(0, 8, 8'h01);
    repeat (39) cyc();
    rd_reg(0, 0, v); chk("free_b0", v, 8'h0A);
    rd_reg(0, 1, v); chk("free_b1", v, 8'h00);
    chk("free_irq", irq_n, 1'b1);

    // auto-reload / irq on ch1
    wr_reg(1, 4, 3); wr_reg(1, 5, 0); wr_reg(1, 8, 8'h09);
    wait_flag(1, 1, "match_wait");
    chk("irq_pre", irq_n, 1'b1);
    cyc();
    chk("irq_fall", irq_n, 1'b0);
    rd_reg(1, 9, v); chk("match_sts", v, 8'h01);
    wr_reg(1, 9, 1);
    chk("irq_hold", irq_n, 1'b0);
    cyc();
    chk("irq_clear", irq_n, 1'b1);
    wr_reg(1, 0, 0); wr_reg(1, 1, 0); wr_reg(1, 8, 8'h0B);
    wait_flag(1, 1, "auto_wait");
    rd_reg(1, 0, v); chk("auto_reload", v, 8'h00);
    wr_reg(1, 8, 8'h02); wr_reg(1, 9, 3);

    // one-shot on ch2
    wr_reg(2, 4, 2); wr_reg(2, 5, 0); wr_reg(2, 8, 8'h05);
    wait_flag(2, 1, "os_wait");
    repeat (10) cyc();
    rd_reg(2, 8, v); chk("os_ctl", v, 8'h04);
    rd_reg(2, 0, v); chk("os_cnt", v, 8'h03);
    rd_reg(2, 9, v); chk("os_sts", v, 8'h01);
    wr_reg(2, 9, 3);

    // match beats wrap at all-ones compare, then a real overflow
    wr_reg(3, 0, 8'hFE); wr_reg(3, 1, 8'hFF); wr_reg(3, 8, 8'h11);
    wait_flag(3, 3, "wrapm_wait");
    wr_reg(3, 8, 8'h10);
    rd_reg(3, 0, v); chk("wrapm_cnt", v, 8'h00);
    rd_reg(3, 9, v); chk("wrapm_sts", v, 8'h01);
    chk("wrapm_irq", irq_n, 1'b1);
    wr_reg(3, 9, 3); wr_reg(3, 4, 8'h10); wr_reg(3, 5, 0);
    wr_reg(3, 0, 8'hFE); wr_reg(3, 1, 8'hFF); wr_reg(3, 8, 8'h11);
    wait_flag(3, 3, "ovf_wait");
    wr_reg(3, 8, 8'h10);
    rd_reg(3, 0, v); chk("ovf_cnt", v, 8'h00);
    rd_reg(3, 9, v); chk("ovf_sts", v, 8'h02);
    chk("ovf_irq", irq_n, 1'b0);
    wr_reg(3, 9, 3);

    // bytes above WIDTH and unused registers
    wr_reg(3, 6, 8'hAA);
    rd_reg(3, 6, v); chk("hi_cmp", v, 8'h00);
    rd_reg(3, 2, v); chk("hi_cnt", v, 8'h00);
    rd_reg(3, 12, v); chk("unused", v, 8'h00);

    // snapshot coherence across a tick
    wr_reg(3, 8, 0); wr_reg(3, 0, 8'hFF); wr_reg(3, 1, 8'h00);
    align(2);
    wr_reg(3, 8, 8'h01);
    rd_reg(3, 0, v); chk("snap_b0", v, 8'hFF);
    rd_reg(3, 1, v); chk("snap_b1", v, 8'h00);
    cs = 1; rd = 1; addr = AW'(3 * 16);
    repeat (6) cyc();
    chk("snap_hold", dout, 8'h00);
    cs = 0; rd = 0;
    wr_reg(3, 8, 0);

    // count write on a tick cycle wins
    align(3);
    wr_reg(0, 0, 8'h55);
    rd_reg(0, 0, v); chk("wr_vs_tick", v, 8'h55);

    // W1C on the same edge as a new match
    wr_reg(1, 0, 0); wr_reg(1, 1, 0); wr_reg(1, 8, 8'h0B);
    begin
      int n = 0;
      while (!(m_cnt[1] == 3 && (m_cyc % TD) == TD - 1) && n < 100) begin cyc(); n++; end
      if (n >= 100) chk("w1c_wait", 0, 1);
    end
    wr_reg(1, 9, 1);
    rd_reg(1, 9, v); chk("w1c_vs_match", v, 8'h01);
    chk("w1c_irq", irq_n, 1'b0);

    // reset mid-operation with a write held
    cs = 1; wr = 1; addr = AW'(8); din = 8'h1F; reset = 1;
    cyc();
    reset = 0; cs = 0; wr = 0;
    chk("mrst_irq", irq_n, 1'b1);
    rd_reg(0, 8, v); chk("mrst_ctl", v, 8'h00);
    rd_reg(1, 0, v); chk("mrst_cnt", v, 8'h00);
    rd_reg(1, 4, v); chk("mrst_cmp", v, 8'hFF);
    rd_reg(1, 9, v); chk("mrst_sts", v, 8'h00);

    // randomized traffic, every cycle compared against the model
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom % 400) == 0;
      cs    = ($urandom % 4) != 0;
      rd    = ($urandom % 3) == 0;
      wr    = !rd && (($urandom % 4) == 0);
      addr  = AW'($urandom);
      din   = 8'($urandom);
      if ((int'(addr) & 15) == 5 && ($urandom % 2)) din = 8'h00;
      if ((int'(addr) & 15) == 4 && ($urandom % 2)) din = din & 8'h0F;
      repeat ($urandom_range(1, 3)) cyc();
    end
    reset = 0; cs = 0; rd = 0; wr = 0;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
